// File: rtl/sdiv_param.sv
// sdiv_param: 2N-by-N restoring divider with run-time signed/unsigned mode.
// Operands are loaded over Dbus in three beats: dividend high, dividend low,
// then divisor. Quotient and Remainder are updated only on entry to DONE.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for St; outputs hold reset values
//   LDLO    | capturing dividend low half
//   LDDIV   | capturing divisor
//   CHECK   | form magnitudes, screen divide-by-zero and gross overflow
//   DIV     | one restoring shift/subtract step per cycle, N cycles
//   FIX     | apply result signs, signed range check, publish results
//   DONE    | results valid (Rdy=1); St starts the next operation
module sdiv_param #(
  parameter int N = 16
) (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic         St,
  input  logic         Sgn,
  input  logic [N-1:0] Dbus,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         V,
  output logic         DZ,
  output logic         Rdy,
  output logic         Busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  // 2^(N-1): largest legal magnitude for a negative signed quotient
  localparam logic [N-1:0] HALF = {1'b1, {(N - 1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDLO,
    S_LDDIV,
    S_CHECK,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic [2*N-1:0]   dvd_q, dvd_d;
  logic [N-1:0]     dvs_q, dvs_d;
  logic [N-1:0]     acc_q, acc_d;
  logic [N-1:0]     sh_q, sh_d;
  logic [N-1:0]     dmag_q, dmag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     quo_q, quo_d;
  logic [N-1:0]     rem_q, rem_d;
  logic             v_q, v_d;
  logic             dz_q, dz_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [2*N-1:0]   dvd_mag;
  logic [N-1:0]     dvs_mag;
  logic [N:0]       trial;
  logic [N-1:0]     trial_diff;
  logic             qbit;
  logic             q_neg;
  logic             r_neg;
  logic             q_ovf;

  // Datapath helpers: operand magnitudes, one restoring step, sign fix-up
  always_comb begin
    dvd_mag    = (sgn_q && dvd_q[2*N-1]) ? -dvd_q : dvd_q;
    dvs_mag    = (sgn_q && dvs_q[N-1]) ? -dvs_q : dvs_q;
    // partial remainder is always below the divisor, so the difference fits N bits
    trial      = {acc_q, sh_q[N-1]};
    qbit       = (trial >= {1'b0, dmag_q});
    trial_diff = trial[N-1:0] - dmag_q;
    q_neg      = sgn_q && (dvd_q[2*N-1] ^ dvs_q[N-1]);
    r_neg      = sgn_q && dvd_q[2*N-1];
    q_ovf      = sgn_q && (q_neg ? (sh_q > HALF) : (sh_q >= HALF));
  end

  // Next-state and next-output logic for the load/compute sequence
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    dmag_d  = dmag_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    v_d     = v_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (St) begin
          dvd_d[2*N-1:N] = Dbus;
          sgn_d          = Sgn;
          v_d            = 1'b0;
          dz_d           = 1'b0;
          state_d        = S_LDLO;
        end
      end
      S_LDLO: begin
        dvd_d[N-1:0] = Dbus;
        state_d      = S_LDDIV;
      end
      S_LDDIV: begin
        dvs_d   = Dbus;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (dvs_mag == '0) begin
          dz_d    = 1'b1;
          v_d     = 1'b1;
          quo_d   = '0;
          rem_d   = '0;
          state_d = S_DONE;
        end else if (dvd_mag[2*N-1:N] >= dvs_mag) begin
          // magnitude quotient would need more than N bits
          v_d     = 1'b1;
          quo_d   = '0;
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          acc_d   = dvd_mag[2*N-1:N];
          sh_d    = dvd_mag[N-1:0];
          dmag_d  = dvs_mag;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // sh_q shifts dividend bits out the top and quotient bits in the bottom
        acc_d = qbit ? trial_diff : trial[N-1:0];
        sh_d  = {sh_q[N-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (q_ovf) begin
          v_d   = 1'b1;
          quo_d = '0;
          rem_d = '0;
        end else begin
          quo_d = q_neg ? -sh_q : sh_q;
          rem_d = r_neg ? -acc_q : acc_q;
        end
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rdy_d  = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      dmag_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      v_q     <= 1'b0;
      dz_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      dmag_q  <= dmag_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      v_q     <= v_d;
      dz_q    <= dz_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign V         = v_q;
  assign DZ        = dz_q;
  assign Rdy       = rdy_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_sdiv_param.sv
// Bench for sdiv_param at N=16 and N=8 against an arithmetic reference model.
module tb_sdiv_param;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rstn;
  logic        st16, sgn16, v16, dz16, rdy16, busy16;
  logic [15:0] db16, q16, r16;
  logic        st8, sgn8, v8, dz8, rdy8, busy8;
  logic [7:0]  db8, q8, r8;

  sdiv_param #(.N(16)) dut16 (
    .CLK(CLK), .RSTn(rstn), .St(st16), .Sgn(sgn16), .Dbus(db16),
    .Quotient(q16), .Remainder(r16), .V(v16), .DZ(dz16), .Rdy(rdy16), .Busy(busy16)
  );

  sdiv_param #(.N(8)) dut8 (
    .CLK(CLK), .RSTn(rstn), .St(st8), .Sgn(sgn8), .Dbus(db8),
    .Quotient(q8), .Remainder(r8), .V(v8), .DZ(dz8), .Rdy(rdy8), .Busy(busy8)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] prev_q [2];
  logic [15:0] prev_r [2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int w, input bit s, input bit g, input logic [15:0] d);
    if (w == 16) begin
      st16 = s; sgn16 = g; db16 = d;
    end else begin
      st8 = s; sgn8 = g; db8 = d[7:0];
    end
  endtask

  task automatic sample(input int w, output logic [15:0] q, output logic [15:0] r,
                        output logic v, output logic dz, output logic rdy, output logic busy);
    if (w == 16) begin
      q = q16; r = r16; v = v16; dz = dz16; rdy = rdy16; busy = busy16;
    end else begin
      q = {8'h00, q8}; r = {8'h00, r8}; v = v8; dz = dz8; rdy = rdy8; busy = busy8;
    end
  endtask

  // Reference: integer division truncating toward zero, range-checked afterwards
  task automatic model(input int w, input bit g, input logic [31:0] dvd, input logic [15:0] dvs,
                       output logic [15:0] eq, output logic [15:0] er,
                       output logic ev, output logic edz, output int lat);
    longint full, half, dd, dv, q, r, qmag;
    bit ovf;
    full = longint'(1) << (2 * w);
    half = longint'(1) << (w - 1);
    dd = longint'(dvd) & (full - 1);
    dv = longint'(dvs) & ((longint'(1) << w) - 1);
    if (g) begin
      if (dd >= full / 2) dd = dd - full;
      if (dv >= half) dv = dv - (longint'(1) << w);
    end
    eq = '0; er = '0; ev = 1'b0; edz = 1'b0;
    if (dv == 0) begin
      edz = 1'b1; ev = 1'b1; lat = 1;
      return;
    end
    q = dd / dv;
    r = dd % dv;
    qmag = (q < 0) ? -q : q;
    lat = (qmag >= (longint'(1) << w)) ? 1 : w + 2;
    if (g) ovf = (q > half - 1) || (q < -half);
    else   ovf = (q >= (longint'(1) << w));
    if (ovf) begin
      ev = 1'b1;
    end else begin
      eq = 16'(q & ((longint'(1) << w) - 1));
      er = 16'(r & ((longint'(1) << w) - 1));
    end
  endtask

  task automatic run_op(input int w, input bit g, input logic [31:0] dvd, input logic [15:0] dvs,
                        input string tag);
    logic [15:0] eq, er, q, r, hi, lo;
    logic ev, edz, v, dz, rdy, busy;
    int lat, n, idx;
    idx = (w == 16) ? 0 : 1;
    model(w, g, dvd, dvs, eq, er, ev, edz, lat);
    hi = (w == 16) ? dvd[31:16] : {8'h00, dvd[15:8]};
    lo = (w == 16) ? dvd[15:0]  : {8'h00, dvd[7:0]};
    @(negedge CLK) drive(w, 1'b1, g, hi);
    @(negedge CLK) drive(w, 1'b1, 1'($urandom), lo);
    @(negedge CLK) drive(w, 1'($urandom), 1'($urandom), dvs);
    @(posedge CLK);
    #1;
    sample(w, q, r, v, dz, rdy, busy);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    chk({tag, "_rdy_low"}, {63'd0, rdy}, 64'd0);
    chk({tag, "_qhold"}, {48'd0, q}, {48'd0, prev_q[idx]});
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 40) begin
      drive(w, 1'($urandom), 1'($urandom), 16'($urandom));
      @(posedge CLK);
      #1;
      n++;
      sample(w, q, r, v, dz, rdy, busy);
    end
    drive(w, 1'b0, 1'b0, 16'h0000);
    chk({tag, "_latency"}, 64'(n), 64'(lat));
    chk({tag, "_quot"}, {48'd0, q}, {48'd0, eq});
    chk({tag, "_rem"}, {48'd0, r}, {48'd0, er});
    chk({tag, "_v_dz"}, {62'd0, v, dz}, {62'd0, ev, edz});
    chk({tag, "_busy_done"}, {63'd0, busy}, 64'd0);
    prev_q[idx] = eq;
    prev_r[idx] = er;
  endtask

  task automatic random_ops(input int w, input int count);
    logic [31:0] dvd;
    logic [15:0] dvs;
    for (int i = 0; i < count; i++) begin
      dvd = $urandom;
      dvs = 16'($urandom);
      if (w == 8) dvd = dvd & 32'h0000_FFFF;
      case ($urandom_range(0, 7))
        0: dvs = 16'h0000;
        1, 2, 3, 4: dvd = (w == 16) ? {{8{dvd[31]}}, dvd[31:8]} : {16'h0, {4{dvd[15]}}, dvd[15:4]};
        default: ;
      endcase
      run_op(w, 1'($urandom), dvd, dvs, $sformatf("rnd%0d_%0d", w, i));
    end
  endtask

  logic [15:0] sq, sr;
  logic sv, sdz, srdy, sbusy;

  initial begin
    rstn = 1'b0;
    drive(16, 1'b0, 1'b0, 16'h0);
    drive(8, 1'b0, 1'b0, 16'h0);
    prev_q[0] = '0; prev_r[0] = '0; prev_q[1] = '0; prev_r[1] = '0;
    repeat (2) @(posedge CLK);
    #1;
    sample(16, sq, sr, sv, sdz, srdy, sbusy);
    chk("reset16", {sq, sr, sv, sdz, srdy, sbusy}, 36'h0);
    sample(8, sq, sr, sv, sdz, srdy, sbusy);
    chk("reset8", {sq, sr, sv, sdz, srdy, sbusy}, 36'h0);
    @(negedge CLK) rstn = 1'b1;

    run_op(16, 1'b1, 32'h0000006F, 16'h0007, "s_6f_7");
    run_op(16, 1'b1, 32'hFFFFFE08, 16'h001E, "s_neg_1e");
    run_op(16, 1'b1, 32'hC0008001, 16'h7FFF, "s_c0008001");
    run_op(16, 1'b1, 32'hC0008000, 16'h7FFF, "s_minq");
    run_op(16, 1'b1, 32'h3FFF8000, 16'h7FFF, "s_posovf");
    run_op(16, 1'b1, 32'hFFFFFFFF, 16'h0000, "s_dz");
    run_op(16, 1'b0, 32'h7FFF0000, 16'h8000, "u_7fff");
    run_op(16, 1'b1, 32'h7FFF0000, 16'h8000, "s_7fff_ovf");
    run_op(16, 1'b0, 32'h0000FFFF, 16'h0001, "u_div1");
    run_op(16, 1'b1, 32'h80000000, 16'hFFFF, "s_min_by_m1");
    random_ops(16, 40);

    // Reset in the middle of DIV discards the operation
    @(negedge CLK) drive(16, 1'b1, 1'b1, 16'h0000);
    @(negedge CLK) drive(16, 1'b1, 1'b0, 16'h006F);
    @(negedge CLK) drive(16, 1'b0, 1'b0, 16'h0007);
    repeat (6) @(posedge CLK);
    @(negedge CLK) rstn = 1'b0;
    @(posedge CLK);
    #1;
    sample(16, sq, sr, sv, sdz, srdy, sbusy);
    chk("midreset16", {sq, sr, sv, sdz, srdy, sbusy}, 36'h0);
    sample(8, sq, sr, sv, sdz, srdy, sbusy);
    chk("midreset8", {sq, sr, sv, sdz, srdy, sbusy}, 36'h0);
    @(negedge CLK) rstn = 1'b1;
    prev_q[0] = '0; prev_r[0] = '0; prev_q[1] = '0; prev_r[1] = '0;
    repeat (20) @(posedge CLK);
    #1;
    sample(16, sq, sr, sv, sdz, srdy, sbusy);
    chk("idle_after_reset", {62'd0, srdy, sbusy}, 64'd0);
    run_op(16, 1'b1, 32'h0000006F, 16'h0007, "post_reset");

    run_op(8, 1'b1, 32'h0000006F, 16'h0007, "n8_6f_7");
    run_op(8, 1'b1, 32'h0000C081, 16'h007F, "n8_neg");
    run_op(8, 1'b1, 32'h0000FFFF, 16'h0000, "n8_dz");
    run_op(8, 1'b0, 32'h00007F00, 16'h0080, "n8_u");
    random_ops(8, 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdiv_param.md
Name: sdiv_param

Overview:
- Parametrised successor to the 32/16 signed divider: 2N-bit dividend divided by N-bit divisor.
- Operands arrive over a shared N-bit Dbus in three beats: dividend high, dividend low, then divisor.
- Adds a run-time signed/unsigned mode, exact overflow detection, a separate divide-by-zero flag, a Busy output and synchronous reset.
- Sits in the arithmetic datapath as a multi-cycle slave, started by St and completed by Rdy.

Parameters:
- N, 16, divisor/quotient/remainder width; dividend is 2N bits; N >= 4.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RSTn  in  1  synchronous active-low reset.
- St  in  1  start; high on the dividend-high beat and the dividend-low beat.
- Sgn  in  1  1 = two's-complement signed, 0 = unsigned; sampled on the dividend-high beat.
- Dbus  in  N  operand bus.
- Quotient  out  N  result quotient.
- Remainder  out  N  result remainder.
- V  out  1  overflow: quotient not representable, or divide-by-zero.
- DZ  out  1  divisor was zero.
- Rdy  out  1  results valid.
- Busy  out  1  load or compute in progress.

Behaviour:
- Reset: when RSTn=0 at an edge, the state goes to IDLE and Quotient, Remainder, V, DZ, Rdy and Busy all go to 0. Reset applies in any state, including mid-load or mid-compute; the operation in progress is discarded.
- States: IDLE, LDLO, LDDIV, CHECK, DIV, FIX, DONE.
- IDLE or DONE, St=1: capture Dbus as dividend[2N-1:N] and latch Sgn. Next state LDLO. Rdy, V and DZ clear.
- LDLO: capture Dbus as dividend[N-1:0]. Next state LDDIV. St is expected high but is not checked.
- LDDIV: capture Dbus as the divisor. Next state CHECK.
- CHECK:
  - Form magnitudes. In signed mode: |dividend| is 2N+1-safe and |divisor| is N+1-safe. In unsigned mode: raw values.
  - Divisor = 0: set DZ=1 and V=1, Quotient=0, Remainder=0; go to DONE.
  - |dividend high half| >= |divisor|: set V=1, Quotient=0, Remainder=0; go to DONE. The magnitude quotient would be >= 2^N.
  - Otherwise go to DIV.
- DIV: restoring shift/subtract, one quotient bit per cycle, exactly N cycles. An internal counter runs 0..N-1.
- FIX:
  - Signed mode: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend). Results truncate toward zero.
  - Signed overflow when the magnitude quotient exceeds 2^(N-1)-1 for a positive result, or exceeds 2^(N-1) for a negative result. -2^(N-1) is legal.
  - Unsigned mode: no further overflow check.
  - On overflow: V=1, Quotient=0, Remainder=0.
  - Next state DONE.
- DONE:
  - Rdy=1; outputs hold until the next start or reset.
  - St=1 in DONE behaves as in IDLE: back-to-back operations are allowed.
- Busy=1 in LDLO, LDDIV, CHECK, DIV and FIX; 0 otherwise.
- Latency, counted from the edge that captures the divisor:
  - Normal operation: Rdy rises N+2 edges later.
  - DZ or prescreen overflow: Rdy rises 1 edge later.
- Quotient and Remainder change only on entry to DONE. Before that they keep the previous results.
- St is ignored in LDDIV, CHECK, DIV and FIX.
- Remainder invariant, when V=0: dividend = Quotient*divisor + Remainder, interpreted according to the mode.

Test Plan:
- N=16, Sgn=1, 0000006F / 0007 -> Quotient 000F, Remainder 0006, V=0; Rdy rises 18 edges after the divisor beat.
- Sgn=1, FFFFFE08 / 001E -> Quotient FFF0, Remainder FFE8. Sgn=1, C0008001 / 7FFF -> Quotient 8001, Remainder 8002.
- Sgn=1, C0008000 / 7FFF -> Quotient 8000, Remainder 0000, V=0 (exact -2^15 is legal). Sgn=1, 3FFF8000 / 7FFF -> V=1, Quotient 0, Remainder 0.
- Sgn=1, FFFFFFFF / 0000 -> DZ=1, V=1; Rdy rises 1 edge after the divisor beat.
- Sgn=0, 7FFF0000 / 8000 -> Quotient FFFE, Remainder 0000, V=0. The same operands with Sgn=1 -> V=1.
- RSTn=0 for one edge mid-DIV -> all outputs 0 and state IDLE. A fresh 0000006F / 0007 afterwards completes correctly. Also repeat the test with N=8: 006F / 07 -> Quotient 0F, Remainder 06.
